// File: rtl/mmio_event_queue_pkg.sv
// Shared MMIO store-event record plus the source count and idle value
// used by the event queue blocks.
package MMIOStruct;

  typedef struct packed {
    logic        store;
    logic [3:0]  len;
    logic [31:0] addr;
    logic [63:0] val;
  } MMIOPack;

  localparam int unsigned MMIO_SRC_NUM = 3;
  localparam MMIOPack     MMIO_IDLE    = '0;

endpackage

// File: rtl/mmio_event_queue_push_compact.sv
// Packs the present events of timer/disp/uart into consecutive slots
// in fixed priority order and reports how many are present.
module mmio_push_compact
  import MMIOStruct::*;
(
  input  MMIOPack                          timer_i,
  input  MMIOPack                          disp_i,
  input  MMIOPack                          uart_i,
  output MMIOPack [MMIO_SRC_NUM-1:0]       packs_o,
  output logic    [1:0]                    n_o
);

  MMIOPack [MMIO_SRC_NUM-1:0] src;
  logic    [1:0]              slot;

  assign src = {uart_i, disp_i, timer_i};

  always_comb begin
    packs_o = {MMIO_SRC_NUM{MMIO_IDLE}};
    slot    = '0;
    for (int unsigned s = 0; s < MMIO_SRC_NUM; s++) begin
      if (src[s].store) begin
        packs_o[slot] = src[s];
        slot          = slot + 2'd1;
      end
    end
    n_o = slot;
  end

endmodule

// File: rtl/mmio_event_queue.sv
// Serialises up to three same-cycle MMIO store events into a FIFO and
// presents them one at a time over a valid/ready handshake.
module mmio_event_queue
  import MMIOStruct::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  MMIOPack          timer_mmio,
  input  MMIOPack          disp_mmio,
  input  MMIOPack          uart_mmio,
  input  logic             cosim_ready,
  output MMIOPack          cosim_mmio,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  MMIOPack [MMIO_SRC_NUM-1:0] packs;
  logic    [1:0]              n;
  logic    [1:0]              acc;
  logic    [CNT_W:0]          free;
  logic                       pop;

  MMIOPack          mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  mmio_push_compact u_compact (
    .timer_i (timer_mmio),
    .disp_i  (disp_mmio),
    .uart_i  (uart_mmio),
    .packs_o (packs),
    .n_o     (n)
  );

  // A same-cycle pop releases its slot to this cycle's pushes.
  always_comb begin
    pop  = (count_q != '0) && cosim_ready;
    free = (CNT_W+1)'(DEPTH) - {1'b0, count_q} + {{CNT_W{1'b0}}, pop};
    if ({{(CNT_W-1){1'b0}}, n} <= free) acc = n;
    else                                acc = free[1:0];
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(acc);
    count_d    = count_q + CNT_W'(acc) - CNT_W'(pop);
    overflow_d = overflow_q | (n != acc);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int unsigned i = 0; i < MMIO_SRC_NUM; i++) begin
        if (i < 32'(acc)) mem[wr_ptr_q + PTR_W'(i)] <= packs[i];
      end
    end
  end

  always_comb begin
    cosim_mmio = MMIO_IDLE;
    if (count_q != '0) begin
      cosim_mmio       = mem[rd_ptr_q];
      cosim_mmio.store = 1'b1;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mmio_event_queue.sv
// Directed self-checking bench for mmio_event_queue (DEPTH=8).
module tb_mmio_event_queue;
  import MMIOStruct::*;

  logic       clk = 1'b0;
  logic       rstn;
  MMIOPack    timer_mmio, disp_mmio, uart_mmio, cosim_mmio;
  logic       cosim_ready;
  logic [3:0] count;
  logic       overflow;

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [31:0] A_TMR  = 32'h0200_BFF8;
  localparam logic [31:0] A_DISP = 32'hFFFF_0000;
  localparam logic [31:0] A_UART = 32'h1000_0000;

  mmio_event_queue #(.DEPTH(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .timer_mmio  (timer_mmio),
    .disp_mmio   (disp_mmio),
    .uart_mmio   (uart_mmio),
    .cosim_ready (cosim_ready),
    .cosim_mmio  (cosim_mmio),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  function automatic MMIOPack ev(input logic [31:0] a, input logic [63:0] v, input logic [3:0] l);
    ev       = '0;
    ev.store = 1'b1;
    ev.addr  = a;
    ev.val   = v;
    ev.len   = l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    timer_mmio = '0;
    disp_mmio  = '0;
    uart_mmio  = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    cosim_ready = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (cosim_mmio !== MMIO_IDLE) begin bad++; $display("FAIL reset_out got=%h exp=0", cosim_mmio); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_single();
    MMIOPack e;
    e = ev(A_UART, 64'h41, 4'd1);
    uart_mmio = e;
    cosim_ready = 1'b1;
    total++; if (cosim_mmio !== MMIO_IDLE) begin bad++; $display("FAIL single_nobypass got=%h exp=0", cosim_mmio); end
    step();
    idle_inputs();
    total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", count); end
    total++; if (cosim_mmio !== e) begin bad++; $display("FAIL single_out got=%h exp=%h", cosim_mmio, e); end
    step();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", count); end
    total++; if (cosim_mmio !== MMIO_IDLE) begin bad++; $display("FAIL single_idle got=%h exp=0", cosim_mmio); end
    cosim_ready = 1'b0;
  endtask

  task automatic test_three();
    MMIOPack exp [3];
    exp[0] = ev(A_TMR, 64'h11, 4'd8);
    exp[1] = ev(A_DISP, 64'h22, 4'd4);
    exp[2] = ev(A_UART, 64'h33, 4'd1);
    cosim_ready = 1'b0;
    timer_mmio = exp[0]; disp_mmio = exp[1]; uart_mmio = exp[2];
    step();
    idle_inputs();
    total++; if (count !== 4'd3) begin bad++; $display("FAIL three_count got=%0d exp=3", count); end
    cosim_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (cosim_mmio !== exp[k]) begin bad++; $display("FAIL three_order[%0d] got=%h exp=%h", k, cosim_mmio, exp[k]); end
      step();
    end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL three_drain got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL three_ovf got=%b exp=0", overflow); end
    cosim_ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    MMIOPack exp [8];
    logic [3:0] exp_cnt [3];
    exp_cnt[0] = 4'd3; exp_cnt[1] = 4'd6; exp_cnt[2] = 4'd8;
    cosim_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      timer_mmio = ev(A_TMR,  64'(3*c),   4'd8);
      disp_mmio  = ev(A_DISP, 64'(3*c+1), 4'd4);
      uart_mmio  = ev(A_UART, 64'(3*c+2), 4'd1);
      if (3*c   < 8) exp[3*c]   = timer_mmio;
      if (3*c+1 < 8) exp[3*c+1] = disp_mmio;
      if (3*c+2 < 8) exp[3*c+2] = uart_mmio;
      step();
      total++; if (count !== exp_cnt[c]) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", c, count, exp_cnt[c]); end
    end
    idle_inputs();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
    cosim_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++; if (cosim_mmio !== exp[k]) begin bad++; $display("FAIL fill_drain[%0d] got=%h exp=%h", k, cosim_mmio, exp[k]); end
      step();
    end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL fill_empty got=%0d exp=0", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_sticky got=%b exp=1", overflow); end
    total++; if (cosim_mmio !== MMIO_IDLE) begin bad++; $display("FAIL fill_idle got=%h exp=0", cosim_mmio); end
    cosim_ready = 1'b0;
  endtask

  task automatic test_full_pop_push();
    MMIOPack exp [9];
    do_reset();
    cosim_ready = 1'b0;
    for (int k = 0; k < 8; k++) exp[k] = ev(A_DISP, 64'h200 + 64'(k), 4'd4);
    timer_mmio = exp[0]; disp_mmio = exp[1]; uart_mmio = exp[2]; step();
    timer_mmio = exp[3]; disp_mmio = exp[4]; uart_mmio = exp[5]; step();
    timer_mmio = exp[6]; disp_mmio = exp[7]; uart_mmio = '0;     step();
    total++; if (count !== 4'd8) begin bad++; $display("FAIL fpp_full got=%0d exp=8", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_noovf got=%b exp=0", overflow); end
    exp[8] = ev(A_TMR, 64'hAAA, 4'd8);
    timer_mmio = exp[8];
    disp_mmio  = ev(A_DISP, 64'hBBB, 4'd4);
    uart_mmio  = ev(A_UART, 64'hCCC, 4'd1);
    cosim_ready = 1'b1;
    step();
    idle_inputs();
    total++; if (count !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d exp=8", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fpp_ovf got=%b exp=1", overflow); end
    for (int k = 1; k < 9; k++) begin
      total++; if (cosim_mmio !== exp[k]) begin bad++; $display("FAIL fpp_drain[%0d] got=%h exp=%h", k, cosim_mmio, exp[k]); end
      step();
    end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL fpp_empty got=%0d exp=0", count); end
    cosim_ready = 1'b0;
  endtask

  task automatic test_wrap();
    MMIOPack q[$];
    MMIOPack e;
    int unsigned sent;
    do_reset();
    sent = 0;
    for (int i = 0; i < 48; i++) begin
      idle_inputs();
      if ((i % 2 == 0) && (sent < 20)) timer_mmio = ev(A_TMR, 64'h1000 + 64'(sent), 4'd8);
      cosim_ready = (i % 2 == 1);
      e = (q.size() > 0) ? q[0] : MMIO_IDLE;
      total++; if (cosim_mmio !== e) begin bad++; $display("FAIL wrap_out[%0d] got=%h exp=%h", i, cosim_mmio, e); end
      total++; if (count !== 4'(q.size())) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=%0d", i, count, q.size()); end
      if (cosim_ready && (q.size() > 0)) void'(q.pop_front());
      if (timer_mmio.store) begin q.push_back(timer_mmio); sent++; end
      step();
    end
    idle_inputs();
    cosim_ready = 1'b0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_empty got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_reset_mid();
    MMIOPack e;
    do_reset();
    cosim_ready = 1'b0;
    timer_mmio = ev(A_TMR, 64'h1, 4'd8);
    disp_mmio  = ev(A_DISP, 64'h2, 4'd4);
    uart_mmio  = ev(A_UART, 64'h3, 4'd1);
    step();
    uart_mmio = '0;
    step();
    total++; if (count !== 4'd5) begin bad++; $display("FAIL rmid_count5 got=%0d exp=5", count); end
    // force an overflow so the reset has something to clear
    timer_mmio = ev(A_TMR, 64'h4, 4'd8);
    disp_mmio  = ev(A_DISP, 64'h5, 4'd4);
    uart_mmio  = ev(A_UART, 64'h6, 4'd1);
    step();
    step();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL rmid_ovf_set got=%b exp=1", overflow); end
    rstn = 1'b0;
    cosim_ready = 1'b1;
    step();
    rstn = 1'b1;
    idle_inputs();
    cosim_ready = 1'b0;
    total++; if (count !== 4'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", count); end
    total++; if (cosim_mmio.store !== 1'b0) begin bad++; $display("FAIL rmid_store got=%b exp=0", cosim_mmio.store); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rmid_ovf got=%b exp=0", overflow); end
    e = ev(A_UART, 64'h77, 4'd1);
    uart_mmio = e;
    step();
    idle_inputs();
    total++; if (count !== 4'd1) begin bad++; $display("FAIL rmid_push_count got=%0d exp=1", count); end
    total++; if (cosim_mmio !== e) begin bad++; $display("FAIL rmid_push_out got=%h exp=%h", cosim_mmio, e); end
  endtask

  initial begin
    rstn = 1'b0;
    cosim_ready = 1'b0;
    idle_inputs();
    step();
    test_reset();
    test_single();
    test_three();
    test_fill_overflow();
    test_full_pop_push();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_event_queue.md
Name: mmio_event_queue

Overview:
Serialising buffer for cosimulation MMIO store events. Timer, display and UART peripherals can each report a store in the same cycle. This block captures all of them and presents them one at a time, in order, to the cosim checker over a valid/ready handshake. No event is lost unless the buffer overflows, and an overflow is flagged.

Parameters:
DEPTH, 8, number of buffered MMIOPack entries; power of two, >= 4.
CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rstn  input  1  synchronous active-low reset.
timer_mmio  input  MMIOStruct::MMIOPack  timer event; .store=1 means an event is present this cycle.
disp_mmio  input  MMIOStruct::MMIOPack  display event; same convention.
uart_mmio  input  MMIOStruct::MMIOPack  UART event; same convention.
cosim_ready  input  1  checker accepts the head entry this cycle.
cosim_mmio  output  MMIOStruct::MMIOPack  head entry; .store=1 means valid.
count  output  CNT_W  current occupancy.
overflow  output  1  sticky flag: at least one event was dropped.

Behaviour:
- Reset (rstn=0 at posedge):
  - rd_ptr=0, wr_ptr=0, count=0, overflow=0.
  - cosim_mmio = all-zero pack (store=0).
  - Storage contents are don't-care.
  - Reset mid-stream discards all entries and any same-cycle push or pop.
- Output is combinational from the head entry:
  - count==0: cosim_mmio = all-zero pack.
  - count>0: cosim_mmio = mem[rd_ptr], with store forced to 1.
- Pop: pop = (count>0) & cosim_ready. On pop, rd_ptr advances by 1 modulo DEPTH. cosim_ready while empty has no effect.
- Push count: n = timer.store + disp.store + uart.store, range 0..3.
- Free space: free = DEPTH - count + pop. A same-cycle pop frees a slot for that cycle's push.
- Accepted pushes: acc = min(n, free).
  - Events are taken in fixed priority order timer, disp, uart, skipping inputs with store=0.
  - The first acc present events are written to wr_ptr, wr_ptr+1, ... (modulo DEPTH).
  - wr_ptr advances by acc.
- Drops: if n > acc, the lowest-priority excess events are dropped and overflow is set. overflow is cleared only by reset.
- count_next = count + acc - pop. count never exceeds DEPTH and never underflows.
- Latency: an event pushed in cycle t appears on cosim_mmio in cycle t+1 at the earliest. There is no bypass path.
- Ordering: FIFO across cycles. Within a cycle the order is timer, disp, uart.
- Entries hold len/val/addr unchanged. Only the store bit is regenerated on output.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided by count, not by pointer equality.
- Simultaneous full + pop + 3 pushes: free=1, so only the timer event is accepted and overflow is set.
- Inputs with store=0 are ignored regardless of their other fields.

Decomposition:
- MMIOStruct package: keep MMIOPack there. Add the constant MMIO_SRC_NUM=3 and a zero-valued MMIOPack constant (MMIO_IDLE) so every block shares one idle value.
- One sub-module, mmio_push_compact (combinational):
  - Input: the three packs.
  - Outputs: a compacted array of up to 3 packs in priority order, plus n.
  - The top level holds pointers, count, storage and the overflow logic.

Test Plan:
- Single event: only uart_mmio.store=1 (addr=0x1000_0000, val=0x41, len=1); cosim_ready=1 -> cosim_mmio holds the same fields with store=1 in the next cycle, then is idle; count goes 1 -> 0.
- Three simultaneous events: all three stores=1 with addr 0x0200_BFF8, 0xFFFF_0000, 0x1000_0000; cosim_ready=0 -> count=3. Then cosim_ready=1 -> output order is timer, disp, uart over 3 cycles; overflow=0.
- Fill and overflow: cosim_ready=0; three-event bursts over 3 cycles (9 events, DEPTH=8) -> count=8; the third cycle's uart event is dropped; overflow=1 and stays 1 through a full drain.
- Full + pop + push: count=8, cosim_ready=1, all three stores=1 -> count stays 8; only the timer event is accepted; overflow set.
- Wrap-around: 20 single events with cosim_ready toggling 1/0 -> all 20 emerge in order with intact val fields; pointers wrap at least twice.
- Reset mid-stream: count=5, then rstn=0 for one cycle with stores asserted -> count=0, cosim_mmio.store=0, overflow=0; the next push behaves normally.
